// File: rtl/i2c_defs_pkg.sv
// Shared I2C definitions: FSM state encodings, ACK levels and field widths.
// Used by the target and by the master SDA/SCL generators.
package i2c_defs;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_READ      = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_e;

endpackage

// File: rtl/i2c_target_if.sv
// User-side handshake of the I2C target: write-byte strobe, read-byte request, status.
interface i2c_target_if;
  import i2c_defs::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              addressed;
  logic              busy;

  modport slave (
    output rx_data, rx_valid, tx_req, addressed, busy,
    input  tx_data
  );

  modport master (
    input  rx_data, rx_valid, tx_req, addressed, busy,
    output tx_data
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges and START/STOP conditions.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    sda_prev_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle-bus level so leaving reset never fakes an edge or START
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_c = scl_s & ~scl_prev_q;
  assign scl_fall_c = ~scl_s & scl_prev_q;
  assign start_c    = scl_s & scl_prev_q & sda_prev_q & ~sda_o;
  assign stop_c     = scl_s & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_target.sv
// I2C target: matches OWN_ADDR, ACKs, delivers written bytes and fetches read bytes from user logic.
module i2c_target
  import i2c_defs::*;
#(
  parameter logic [ADDR_W-1:0] OWN_ADDR    = 7'h2A,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         scl,
  inout  wire          sda,
  i2c_target_if.slave  usr
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] ACK_SLOT = CNT_W'(DATA_W);

  logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl),
    .sda_i      (sda),
    .sda_o      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  i2c_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic rw_q, rw_d;
  logic sda_low_q, sda_low_d;
  logic ack_go_q, ack_go_d;
  logic load_q, load_d;
  logic rx_pend_q, rx_pend_d;
  logic rx_valid_q, rx_valid_d;
  logic tx_req_q, tx_req_d;
  logic addressed_q, addressed_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rw_d        = rw_q;
    sda_low_d   = sda_low_q;
    addressed_d = addressed_q;
    busy_d      = busy_q;
    ack_go_d    = 1'b0;
    rx_pend_d   = 1'b0;
    tx_req_d    = 1'b0;
    rx_valid_d  = rx_pend_q;
    load_d      = tx_req_q;

    // Read byte is sampled two clocks after the request strobe
    if (load_q) begin
      shift_d = usr.tx_data;
    end

    if (start_c) begin
      state_d     = ST_ADDR;
      cnt_d       = '0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
      sda_low_d   = 1'b0;
    end else if (stop_c) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      sda_low_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise_c) begin
            shift_d = {shift_q[DATA_W-2:0], sda_s};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              rw_d    = sda_s;
              cnt_d   = ACK_SLOT;
              state_d = (shift_q[ADDR_W-1:0] == OWN_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
            end
          end
        end
        // sda_low_q tells the first fall (start ACK) from the 9th fall (end ACK)
        ST_ADDR_ACK: begin
          if (ack_go_q && rw_q) begin
            tx_req_d = 1'b1;
          end
          if (scl_fall_c) begin
            if (!sda_low_q) begin
              sda_low_d   = 1'b1;
              addressed_d = 1'b1;
              ack_go_d    = 1'b1;
            end else begin
              cnt_d     = '0;
              state_d   = rw_q ? ST_READ : ST_WRITE;
              sda_low_d = rw_q ? ~shift_q[DATA_W-1] : 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (scl_rise_c) begin
            shift_d = {shift_q[DATA_W-2:0], sda_s};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              rx_data_d = {shift_q[DATA_W-2:0], sda_s};
              rx_pend_d = 1'b1;
              cnt_d     = ACK_SLOT;
              state_d   = ST_WR_ACK;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall_c) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              cnt_d     = '0;
              state_d   = ST_WRITE;
            end
          end
        end
        ST_READ: begin
          if (scl_fall_c) begin
            sda_low_d = ~shift_q[DATA_W-1];
          end
          if (scl_rise_c) begin
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              cnt_d   = ACK_SLOT;
              state_d = ST_RD_ACK;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_fall_c) begin
            sda_low_d = 1'b0;
          end
          if (scl_rise_c) begin
            cnt_d = '0;
            if (sda_s == ACK) begin
              tx_req_d = 1'b1;
              state_d  = ST_READ;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_WAIT_STOP: sda_low_d = 1'b0;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rw_q        <= 1'b0;
      sda_low_q   <= 1'b0;
      ack_go_q    <= 1'b0;
      load_q      <= 1'b0;
      rx_pend_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      addressed_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rw_q        <= rw_d;
      sda_low_q   <= sda_low_d;
      ack_go_q    <= ack_go_d;
      load_q      <= load_d;
      rx_pend_q   <= rx_pend_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      addressed_q <= addressed_d;
      busy_q      <= busy_d;
    end
  end

  // Open-drain: only ever pull low or release
  assign sda = sda_low_q ? 1'b0 : 1'bz;

  assign usr.rx_data   = rx_data_q;
  assign usr.rx_valid  = rx_valid_q;
  assign usr.tx_req    = tx_req_q;
  assign usr.addressed = addressed_q;
  assign usr.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C master BFM on pulled-up wires plus a transaction-level model.
module tb_i2c_target;
  import i2c_defs::*;

  localparam logic [6:0] OWN = 7'h2A;

  logic clk = 1'b0;
  logic reset;
  logic scl;
  logic m_low;
  wire  sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target_if u_if ();
  logic [7:0] tx_byte = 8'h00;
  assign u_if.tx_data = tx_byte;

  i2c_target #(.OWN_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .scl   (scl),
    .sda   (sda),
    .usr   (u_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bytes the target must deliver, bytes it must send, request strobes owed
  logic [7:0] exp_rx[$];
  logic [7:0] rd_bytes[$];
  int rx_seen = 0, tx_seen = 0, tx_exp = 0, rd_chk = 0, rd_idx = 0;
  bit quiet = 1'b0;
  bit prev_rx = 1'b0, prev_tx = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of user-side strobes and bus behaviour against the model
  always @(negedge clk) begin
    if (u_if.rx_valid) begin
      if (rx_seen < exp_rx.size()) check("rx_data", u_if.rx_data, exp_rx[rx_seen]);
      else begin
        n_checks++; n_fail++;
        $display("FAIL rx_valid_unexpected: got rx_data 0x%0h with no byte expected", u_if.rx_data);
      end
      check("rx_valid_width", 32'(prev_rx), 0);
      rx_seen++;
    end
    if (u_if.tx_req) begin
      check("tx_req_expected", 32'(tx_seen < tx_exp), 1);
      check("tx_req_width", 32'(prev_tx), 0);
      check("strobe_overlap", 32'(u_if.rx_valid), 0);
      tx_seen++;
    end
    if (quiet && !m_low) check("sda_not_driven", 32'(sda), 1);
    if (quiet) check("addressed_quiet", 32'(u_if.addressed), 0);
    prev_rx = u_if.rx_valid;
    prev_tx = u_if.tx_req;
  end

  // User read-data source: answers each request with the next queued byte
  always @(negedge clk) begin
    if (u_if.tx_req && rd_idx < rd_bytes.size()) begin
      tx_byte = rd_bytes[rd_idx];
      rd_idx++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SCL period 10 clk: 5 low, 5 high; SDA changes 2 clk into the low phase
  task automatic bus_start();
    m_low = 1'b0; w(2); scl = 1'b1; w(3); m_low = 1'b1; w(3); scl = 1'b0; w(2);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; w(3); scl = 1'b1; w(3); m_low = 1'b0; w(4);
  endtask

  task automatic bit_x(input logic b, output logic s);
    m_low = ~b; w(3); scl = 1'b1; w(2); s = sda; w(3); scl = 1'b0; w(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(1'b1, d[i]);
    bit_x(mack, s);
  endtask

  task automatic wr_addr(input logic [6:0] a, input logic rw, output logic ack);
    if (a == OWN && rw) tx_exp++;
    send_byte({a, rw}, ack);
    check("addr_ack", 32'(ack), 32'((a == OWN) ? ACK : NACK));
  endtask

  task automatic wr_data(input logic [7:0] d, input bit hit, output logic ack);
    if (hit) exp_rx.push_back(d);
    send_byte(d, ack);
    check("data_ack", 32'(ack), 32'(hit ? ACK : NACK));
  endtask

  task automatic rd_data(input logic mack, output logic [7:0] d);
    if (mack == ACK) tx_exp++;
    recv_byte(mack, d);
    if (rd_chk < rd_bytes.size()) check("read_bits", d, rd_bytes[rd_chk]);
    rd_chk++;
  endtask

  initial begin
    logic ack;
    logic [7:0] d;
    logic [2:0] part;
    int rx0, tx0;

    reset = 1'b0; scl = 1'b1; m_low = 1'b0;
    w(5);
    check("rst_rx_data", u_if.rx_data, 0);
    check("rst_rx_valid", 32'(u_if.rx_valid), 0);
    check("rst_tx_req", 32'(u_if.tx_req), 0);
    check("rst_addressed", 32'(u_if.addressed), 0);
    check("rst_busy", 32'(u_if.busy), 0);
    check("rst_sda", 32'(sda), 1);
    reset = 1'b1;
    w(5);

    // Write 0x2A/W, 0x5C, STOP
    bus_start();
    check("t1_busy", 32'(u_if.busy), 1);
    wr_addr(OWN, 1'b0, ack);
    check("t1_addr_ack_lit", 32'(ack), 0);
    check("t1_addressed", 32'(u_if.addressed), 1);
    wr_data(8'h5C, 1'b1, ack);
    check("t1_data_ack_lit", 32'(ack), 0);
    bus_stop();
    check("t1_rx_data_lit", u_if.rx_data, 8'h5C);
    check("t1_rx_count", rx_seen, 1);
    check("t1_busy_after_stop", 32'(u_if.busy), 0);
    check("t1_addressed_after_stop", 32'(u_if.addressed), 0);

    // Foreign address 0x2B/W, 0xFF: target stays silent
    quiet = 1'b1;
    bus_start();
    wr_addr(7'h2B, 1'b0, ack);
    check("t2_addr_nack_lit", 32'(ack), 1);
    wr_data(8'hFF, 1'b0, ack);
    check("t2_data_nack_lit", 32'(ack), 1);
    check("t2_busy_waiting", 32'(u_if.busy), 1);
    bus_stop();
    quiet = 1'b0;
    check("t2_busy_after_stop", 32'(u_if.busy), 0);
    check("t2_rx_count", rx_seen, 1);

    // Read 0x2A/R: 0xA5 (ACK), 0x3C (NACK)
    tx0 = tx_seen;
    rd_bytes.push_back(8'hA5);
    rd_bytes.push_back(8'h3C);
    bus_start();
    wr_addr(OWN, 1'b1, ack);
    rd_data(ACK, d);
    check("t3_byte0_lit", d, 8'hA5);
    rd_data(NACK, d);
    check("t3_byte1_lit", d, 8'h3C);
    w(2);
    check("t3_sda_released", 32'(sda), 1);
    check("t3_tx_req_count", tx_seen - tx0, 2);
    bus_stop();
    check("t3_busy_after_stop", 32'(u_if.busy), 0);

    // Write 0x01, repeated START, read with NACK
    rx0 = rx_seen; tx0 = tx_seen;
    rd_bytes.push_back(8'h99);
    bus_start();
    wr_addr(OWN, 1'b0, ack);
    wr_data(8'h01, 1'b1, ack);
    bus_start();
    check("t4_busy_rs", 32'(u_if.busy), 1);
    wr_addr(OWN, 1'b1, ack);
    check("t4_readdr_ack_lit", 32'(ack), 0);
    check("t4_addressed", 32'(u_if.addressed), 1);
    rd_data(NACK, d);
    check("t4_read_lit", d, 8'h99);
    bus_stop();
    check("t4_rx_once", rx_seen - rx0, 1);
    check("t4_rx_data_lit", u_if.rx_data, 8'h01);
    check("t4_tx_req_once", tx_seen - tx0, 1);

    // Reset during data bit 4 of a write, then a fresh write of 0x77
    rx0 = rx_seen;
    bus_start();
    wr_addr(OWN, 1'b0, ack);
    for (int i = 0; i < 3; i++) bit_x(1'b1, ack);
    m_low = 1'b0; w(3); scl = 1'b1; w(1);
    reset = 1'b0;
    w(1);
    check("t5_sda_released", 32'(sda), 1);
    check("t5_busy", 32'(u_if.busy), 0);
    check("t5_addressed", 32'(u_if.addressed), 0);
    w(2); scl = 1'b0; w(4);
    reset = 1'b1;
    w(4);
    check("t5_no_rx_after_reset", rx_seen - rx0, 0);
    bus_stop();
    bus_start();
    wr_addr(OWN, 1'b0, ack);
    wr_data(8'h77, 1'b1, ack);
    bus_stop();
    check("t5_rx_data_lit", u_if.rx_data, 8'h77);
    check("t5_rx_once", rx_seen - rx0, 1);

    // STOP injected after 3 bits of a read byte (0xB0: next bit is 1, bus free)
    tx0 = tx_seen;
    rd_bytes.push_back(8'hB0);
    rd_chk++;
    bus_start();
    wr_addr(OWN, 1'b1, ack);
    bit_x(1'b1, part[2]);
    bit_x(1'b1, part[1]);
    bit_x(1'b1, part[0]);
    check("t6_partial_bits_lit", 32'(part), 3'b101);
    bus_stop();
    check("t6_busy", 32'(u_if.busy), 0);
    check("t6_addressed", 32'(u_if.addressed), 0);
    check("t6_sda_released", 32'(sda), 1);
    w(30);
    check("t6_tx_req_once", tx_seen - tx0, 1);

    check("all_rx_delivered", rx_seen, exp_rx.size());
    check("all_tx_req_seen", tx_seen, tx_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
